pipe_ctrl: RTL and testbench

Central pipeline stall/flush controller for the 5-stage core. It collects hazard and wait requests from the ID, EX and MEM stages. Each cycle it produces a per-register hold vector and a flush strobe that drive the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM tracks multi-cycle EX operations with a timeout guard, and defers branch flushes that arrive while MEM is waiting.

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl_timer.sv | 32 +++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline stall/flush controller.
// Hold vector bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB.
package pipe_ctrl_pkg;

   localparam int STALL_W   = 5;

   localparam int IDX_PC    = 0;
   localparam int IDX_IFID  = 1;
   localparam int IDX_IDEX  = 2;
   localparam int IDX_EXMEM = 3;
   localparam int IDX_MEMWB = 4;

   localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
   localparam logic [STALL_W-1:0] STALL_ID   = 5'b00011;
   localparam logic [STALL_W-1:0] STALL_EX   = 5'b00111;
   localparam logic [STALL_W-1:0] STALL_MEM  = 5'b01111;

   typedef enum logic {
      RUN     = 1'b0,
      EX_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_ctrl_timer.sv
// Timeout counter for multi-cycle EX operations.
// Cleared on entry to EX_WAIT, frozen while memory stalls; hit at EX_TIMEOUT-1.
module pipe_ctrl_timer #(
   parameter int EX_TIMEOUT = 64,
   parameter int CNT_W      = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic frz,
   output logic hit
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(EX_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Count wait cycles; clear wins, a memory stall freezes the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !frz) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign hit = (cnt == LAST);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int EX_TIMEOUT = 64,
   parameter int CNT_W      = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_id_stallreq,
   input  logic        i_ex_stallreq,
   input  logic        i_ex_done,
   input  logic        i_ex_flushreq,
   input  logic        i_mem_stallreq,
   output logic [4:0]  o_stall,
   output logic        o_flush,
   output logic        o_busy,
   output logic        o_timeout,
   output logic [31:0] o_stall_cycles,
   output logic [31:0] o_flush_count
);

   state_t state;
   state_t state_nx;

   logic               flush_pend;
   logic               pend_nx;
   logic               tmo_q;
   logic               tmo_nx;
   logic               hit;
   logic               ex_wait;
   logic               t_clr;
   logic               t_en;
   logic               fl_req;
   logic               flush;
   logic [STALL_W-1:0] stall;

   pipe_ctrl_timer #(
      .EX_TIMEOUT (EX_TIMEOUT),
      .CNT_W      (CNT_W)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (t_clr),
      .en  (t_en),
      .frz (i_mem_stallreq),
      .hit (hit)
   );

   // State, pending flush and timeout pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         flush_pend <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state      <= state_nx;
         flush_pend <= pend_nx;
         tmo_q      <= tmo_nx;
      end
   end

   // Next state, EX hold and timer control.
   always_comb begin
      state_nx = state;
      ex_wait  = 1'b0;
      t_clr    = 1'b0;
      t_en     = 1'b0;
      tmo_nx   = 1'b0;
      unique case (state)
         RUN: begin
            if (i_ex_stallreq && !i_ex_done) begin
               state_nx = EX_WAIT;
               ex_wait  = 1'b1;
               t_clr    = 1'b1;
            end
         end
         EX_WAIT: begin
            if (i_ex_done) begin
               state_nx = RUN;
            end else if (hit) begin
               state_nx = RUN;
               tmo_nx   = 1'b1;
            end else begin
               ex_wait  = 1'b1;
               t_en     = 1'b1;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   // Flush request, deferral across memory stalls, and hold pattern.
   always_comb begin
      fl_req  = i_ex_flushreq && (state == RUN);
      flush   = !i_mem_stallreq && (fl_req || flush_pend);
      pend_nx = i_mem_stallreq && (fl_req || flush_pend);
      stall   = STALL_NONE;
      priority case (1'b1)
         i_mem_stallreq:           stall = STALL_MEM;
         ex_wait:                  stall = STALL_EX;
         i_id_stallreq && !flush:  stall = STALL_ID;
         default:                  stall = STALL_NONE;
      endcase
   end

   assign o_stall   = rst ? stall : STALL_NONE;
   assign o_flush   = rst && flush;
   assign o_busy    = (state == EX_WAIT);
   assign o_timeout = tmo_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   // Count stalled cycles and flush pulses; both wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= 32'h0;
         flush_cnt <= 32'h0;
      end else begin
         if (|o_stall) stall_cnt <= stall_cnt + 32'd1;
         if (o_flush)  flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign o_stall_cycles = stall_cnt;
   assign o_flush_count  = flush_cnt;
`else
   assign o_stall_cycles = 32'h0;
   assign o_flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl with EX_TIMEOUT=8.
// Expectations are queued when a cycle is driven and checked mid-cycle.
module tb_pipe_ctrl;

   typedef struct {
      logic [4:0] stall;
      logic       flush;
      logic       busy;
      logic       tmo;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        id_req;
   logic        ex_req;
   logic        ex_done;
   logic        fl_req;
   logic        mem_req;
   logic [4:0]  stall;
   logic        flush;
   logic        busy;
   logic        tmo;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   int checks;
   int errors;
   int exp_sc;
   int exp_fc;
   int step_no;
   exp_t sb[$];

   pipe_ctrl #(
      .EX_TIMEOUT (8),
      .CNT_W      (7)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_id_stallreq  (id_req),
      .i_ex_stallreq  (ex_req),
      .i_ex_done      (ex_done),
      .i_ex_flushreq  (fl_req),
      .i_mem_stallreq (mem_req),
      .o_stall        (stall),
      .o_flush        (flush),
      .o_busy         (busy),
      .o_timeout      (tmo),
      .o_stall_cycles (stall_cycles),
      .o_flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h want %0h",
                  tag, step_no, act, exp);
      end
   endtask

   // One cycle: drive inputs after the edge and queue what must appear.
   task automatic step(input logic r, input logic id, input logic ex,
                       input logic dn, input logic fl, input logic mem,
                       input logic [4:0] es, input logic ef,
                       input logic eb, input logic et);
      exp_t e;
      @(posedge clk);
      #1;
      rst     = r;
      id_req  = id;
      ex_req  = ex;
      ex_done = dn;
      fl_req  = fl;
      mem_req = mem;
      e.stall = es;
      e.flush = ef;
      e.busy  = eb;
      e.tmo   = et;
      sb.push_back(e);
      if (!r) begin
         exp_sc = 0;
         exp_fc = 0;
      end else begin
         if (es != 5'b0) exp_sc++;
         if (ef) exp_fc++;
      end
   endtask

   // Monitor: compare each queued expectation mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         step_no++;
         chk("stall", 32'(stall), 32'(e.stall));
         chk("flush", 32'(flush), 32'(e.flush));
         chk("busy",  32'(busy),  32'(e.busy));
         chk("tmo",   32'(tmo),   32'(e.tmo));
      end
   end

   localparam logic [4:0] S0 = 5'b00000;
   localparam logic [4:0] SI = 5'b00011;
   localparam logic [4:0] SE = 5'b00111;
   localparam logic [4:0] SM = 5'b01111;

   initial begin
      checks  = 0;
      errors  = 0;
      exp_sc  = 0;
      exp_fc  = 0;
      step_no = 0;
      rst     = 1'b0;
      id_req  = 1'b1;
      ex_req  = 1'b1;
      ex_done = 1'b1;
      fl_req  = 1'b1;
      mem_req = 1'b1;

      // reset with every request high
      repeat (3) step(0, 1,1,1,1,1, S0,0,0,0);
      @(negedge clk);
      #1;
      chk("rst_sc", stall_cycles, 32'h0);
      chk("rst_fc", flush_count,  32'h0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // load-use stall for one cycle
      step(1, 1,0,0,0,0, SI,0,0,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // multi-cycle op, done five cycles later
      step(1, 0,1,0,0,0, SE,0,0,0);
      repeat (4) step(1, 0,0,0,0,0, SE,0,1,0);
      step(1, 0,0,1,0,0, S0,0,1,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // zero-wait op stays in RUN
      step(1, 0,1,1,0,0, S0,0,0,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // timeout with no done
      step(1, 0,1,0,0,0, SE,0,0,0);
      repeat (7) step(1, 0,0,0,0,0, SE,0,1,0);
      step(1, 0,0,0,0,0, S0,0,1,0);
      step(1, 0,0,0,0,0, S0,0,0,1);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // mem stall with two deferred flush requests merged
      step(1, 0,0,0,0,1, SM,0,0,0);
      step(1, 0,0,0,1,1, SM,0,0,0);
      step(1, 0,0,0,1,1, SM,0,0,0);
      step(1, 0,0,0,0,1, SM,0,0,0);
      step(1, 0,0,0,0,0, S0,1,0,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // immediate flush, and flush masking an id stall
      step(1, 0,0,0,1,0, S0,1,0,0);
      step(1, 1,0,0,1,0, S0,1,0,0);
      step(1, 1,0,0,0,0, SI,0,0,0);

      // flush ignored in EX_WAIT; id stall subsumed
      step(1, 0,1,0,0,0, SE,0,0,0);
      step(1, 1,0,0,1,0, SE,0,1,0);
      step(1, 0,0,1,0,0, S0,0,1,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // mem stall during EX_WAIT takes priority
      step(1, 0,1,0,0,0, SE,0,0,0);
      step(1, 0,0,0,0,1, SM,0,1,0);
      step(1, 0,0,1,0,0, S0,0,1,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // counters before reset discards them
      @(negedge clk);
      #1;
`ifdef PIPE_CTRL_PERF_EN
      chk("sc_mid", stall_cycles, 32'(exp_sc));
      chk("fc_mid", flush_count,  32'(exp_fc));
`else
      chk("sc_mid", stall_cycles, 32'h0);
      chk("fc_mid", flush_count,  32'h0);
`endif

      // reset drops a pending flush
      step(1, 0,0,0,1,1, SM,0,0,0);
      step(0, 0,0,0,0,0, S0,0,0,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // reset mid EX_WAIT returns to RUN
      step(1, 0,1,0,0,0, SE,0,0,0);
      step(1, 0,0,0,0,0, SE,0,1,0);
      step(0, 0,0,0,0,0, S0,0,0,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      // a short stalled run after reset for the counters
      step(1, 1,0,0,0,0, SI,0,0,0);
      step(1, 0,0,0,1,0, S0,1,0,0);
      step(1, 0,0,0,0,0, S0,0,0,0);

      @(negedge clk);
      #1;
`ifdef PIPE_CTRL_PERF_EN
      chk("sc_end", stall_cycles, 32'(exp_sc));
      chk("fc_end", flush_count,  32'(exp_fc));
`else
      chk("sc_end", stall_cycles, 32'h0);
      chk("fc_end", flush_count,  32'h0);
`endif
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
